// File: rtl/fetch_pc_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_pc_sequencer
//
// Instruction-fetch PC sequencer for a single-issue in-order pipeline. It
// keeps at most one fetch outstanding. The flow is request -> wait for the
// instruction -> present it to the IF/ID register. An EX-stage redirect can
// arrive at any point. When it does, the PC is reloaded with the word-aligned
// branch target. Any fetch already in flight is marked for discard, so its
// response is dropped.
//
// Ports
//   clk            : single clock, rising-edge state updates
//   rst_n          : asynchronous active-low reset
//   branch_taken   : one-cycle redirect strobe from EX
//   branch_target  : redirect PC, low two bits ignored (word aligned)
//   imem_req_valid : fetch request valid (only while requesting)
//   imem_req_addr  : fetch address, always the current pc register
//   imem_req_ready : memory accepts the request this cycle
//   imem_rsp_valid : one-cycle instruction return strobe
//   imem_rsp_data  : returned instruction word
//   ifid_valid     : instruction held for the IF/ID register
//   ifid_pc        : PC of the held instruction
//   ifid_instr     : held instruction word
//   ifid_ready     : IF/ID accepts the held instruction this cycle
// -----------------------------------------------------------------------------
module fetch_pc_sequencer #(
    parameter int                PC_W     = 33,
    parameter int                INSTR_W  = 32,
    parameter logic [PC_W-1:0]   RESET_PC = {PC_W{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 branch_taken,
    input  logic [PC_W-1:0]      branch_target,
    output logic                 imem_req_valid,
    output logic [PC_W-1:0]      imem_req_addr,
    input  logic                 imem_req_ready,
    input  logic                 imem_rsp_valid,
    input  logic [INSTR_W-1:0]   imem_rsp_data,
    output logic                 ifid_valid,
    output logic [PC_W-1:0]      ifid_pc,
    output logic [INSTR_W-1:0]   ifid_instr,
    input  logic                 ifid_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(3'd4);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(2'b11));

    state_t               state_r;
    state_t               state_next_s;
    logic [PC_W-1:0]      pc_r;
    logic [PC_W-1:0]      pc_next_s;
    logic                 discard_r;
    logic                 discard_next_s;
    logic                 capture_s;
    logic                 fire_s;
    logic [PC_W-1:0]      redirect_pc_s;
    logic [PC_W-1:0]      pc_plus4_s;
    logic                 imem_req_valid_r;
    logic                 ifid_valid_r;
    logic [PC_W-1:0]      ifid_pc_r;
    logic [INSTR_W-1:0]   ifid_instr_r;

    // The request is only driven in REQ, so the handshake reduces to ready there.
    assign fire_s        = (state_r == ST_REQ) & imem_req_ready;
    // Clearing the low bits with a mask keeps the redirect word aligned.
    assign redirect_pc_s = branch_target & ALIGN_MASK;
    // Plain modulo-2^PC_W increment; the carry out is dropped on purpose.
    assign pc_plus4_s    = pc_r + PC_STEP;

    // Next-state, next-pc, discard flag and capture strobe.
    always_comb begin
        state_next_s   = state_r;
        pc_next_s      = pc_r;
        discard_next_s = discard_r;
        capture_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Redirects are ignored until the sequencer is running.
                state_next_s = ST_REQ;
            end
            ST_REQ: begin
                if (branch_taken) begin
                    pc_next_s      = redirect_pc_s;
                    // A redirect racing an accepted request poisons that fetch.
                    discard_next_s = fire_s;
                end else begin
                    pc_next_s = pc_r;
                end
                if (fire_s) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    if (discard_r || branch_taken) begin
                        discard_next_s = 1'b0;
                        state_next_s   = ST_REQ;
                        if (branch_taken) begin
                            pc_next_s = redirect_pc_s;
                        end else begin
                            pc_next_s = pc_r;
                        end
                    end else begin
                        capture_s    = 1'b1;
                        pc_next_s    = pc_plus4_s;
                        state_next_s = ST_OUT;
                    end
                end else if (branch_taken) begin
                    pc_next_s      = redirect_pc_s;
                    discard_next_s = 1'b1;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_OUT: begin
                // A redirect flushes the held instruction even if IF/ID is ready.
                if (branch_taken) begin
                    pc_next_s    = redirect_pc_s;
                    state_next_s = ST_REQ;
                end else if (ifid_ready) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_OUT;
                end
            end
            default: begin
                state_next_s   = ST_IDLE;
                pc_next_s      = RESET_PC;
                discard_next_s = 1'b0;
            end
        endcase
    end

    // State, pc and discard flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            pc_r      <= RESET_PC;
            discard_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            pc_r      <= pc_next_s;
            discard_r <= discard_next_s;
        end
    end

    // IF/ID payload: loaded only on capture, so it stays stable throughout OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_pc_r    <= {PC_W{1'b0}};
            ifid_instr_r <= {INSTR_W{1'b0}};
        end else if (capture_s) begin
            ifid_pc_r    <= pc_r;
            ifid_instr_r <= imem_rsp_data;
        end else begin
            ifid_pc_r    <= ifid_pc_r;
            ifid_instr_r <= ifid_instr_r;
        end
    end

    // Valid flags are registered from the next state so they track state_r exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_req_valid_r <= 1'b0;
            ifid_valid_r     <= 1'b0;
        end else begin
            imem_req_valid_r <= (state_next_s == ST_REQ);
            ifid_valid_r     <= (state_next_s == ST_OUT);
        end
    end

    assign imem_req_valid = imem_req_valid_r;
    assign imem_req_addr  = pc_r;
    assign ifid_valid     = ifid_valid_r;
    assign ifid_pc        = ifid_pc_r;
    assign ifid_instr     = ifid_instr_r;

    fetch_pc_sequencer_checker #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_checker (
        .clk            (clk),
        .rst_n          (rst_n),
        .branch_taken   (branch_taken),
        .imem_req_valid (imem_req_valid_r),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (pc_r),
        .ifid_valid     (ifid_valid_r),
        .ifid_pc        (ifid_pc_r),
        .ifid_instr     (ifid_instr_r)
    );

endmodule

// -----------------------------------------------------------------------------
// fetch_pc_sequencer_checker
//
// Protocol properties of the fetch sequencer outputs. It only observes and
// drives nothing.
// Ports: clk, rst_n, branch_taken, the request handshake/address and the
// IF/ID valid/payload.
// -----------------------------------------------------------------------------
module fetch_pc_sequencer_checker #(
    parameter int PC_W    = 33,
    parameter int INSTR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 branch_taken,
    input  logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    input  logic [PC_W-1:0]      imem_req_addr,
    input  logic                 ifid_valid,
    input  logic [PC_W-1:0]      ifid_pc,
    input  logic [INSTR_W-1:0]   ifid_instr
);

    // Requesting and presenting are distinct states and never overlap.
    a_exclusive_valids: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(imem_req_valid && ifid_valid));

    // A stalled request holds its address unless a redirect arrives.
    a_req_addr_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (imem_req_valid && !imem_req_ready && !branch_taken)
        |=> (imem_req_valid && $stable(imem_req_addr)));

    // The held instruction does not change while it is being presented.
    a_ifid_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (ifid_valid && $past(ifid_valid))
        |-> ($stable(ifid_pc) && $stable(ifid_instr)));

endmodule

// File: doc/fetch_pc_sequencer.md
FETCH_PC_SEQUENCER -- requirements
Module: fetch_pc_sequencer

Interface
REQ-001 Parameter: PC_W, 33, width of every PC/address bus; equals the branch-target bus width.
REQ-002 Parameter: INSTR_W, 32, instruction word width.
REQ-003 Parameter: RESET_PC, 0, PC loaded on reset.
REQ-004 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: branch_taken  input  1  EX-stage redirect strobe, one cycle per redirect.
REQ-007 Port: branch_target  input  PC_W  redirect PC (PC + branch immediate), sampled when branch_taken=1.
REQ-008 Port: imem_req_valid  output  1  fetch request valid.
REQ-009 Port: imem_req_addr  output  PC_W  fetch address.
REQ-010 Port: imem_req_ready  input  1  memory accepts request; request fires when valid and ready are both 1.
REQ-011 Port: imem_rsp_valid  input  1  instruction return strobe, one cycle, only after a fired request.
REQ-012 Port: imem_rsp_data  input  INSTR_W  returned instruction.
REQ-013 Port: ifid_valid  output  1  fetched instruction valid toward IF/ID register.
REQ-014 Port: ifid_pc  output  PC_W  PC of ifid_instr.
REQ-015 Port: ifid_instr  output  INSTR_W  fetched instruction.
REQ-016 Port: ifid_ready  input  1  IF/ID accepts; transfer when ifid_valid and ifid_ready are both 1.

Function
REQ-017 States SHALL be IDLE, REQ, WAIT, OUT; at most one fetch outstanding.
REQ-018 imem_req_valid SHALL be 1 only in REQ; imem_req_addr SHALL equal the pc register.
REQ-019 ifid_valid SHALL be 1 only in OUT; ifid_pc/ifid_instr SHALL hold stable while in OUT.
REQ-020 IDLE SHALL go to REQ on the first clock edge after rst_n deasserts.
REQ-021 REQ: on fire, go to WAIT; without fire, stay in REQ with address stable, except on a redirect.
REQ-022 WAIT: on imem_rsp_valid with no pending discard, capture data into ifid_instr, pc into ifid_pc, set pc to pc+4, go to OUT.
REQ-023 OUT: on transfer, go to REQ (pc already advanced); without transfer, stay in OUT.
REQ-024 Redirect (branch_taken=1) SHALL load pc with {branch_target[PC_W-1:2],2'b00} in any non-IDLE state; it overrides the pc+4 update in the same cycle.
REQ-025 Redirect in REQ with no fire SHALL keep state REQ; the new address SHALL appear on the next cycle.
REQ-026 Redirect in REQ coinciding with fire, or redirect in WAIT, SHALL set the discard flag.
REQ-027 In WAIT, a response with the discard flag set, or coinciding with a redirect, SHALL be dropped: no ifid_valid, discard flag cleared, go to REQ.
REQ-028 Redirect in OUT SHALL deassert ifid_valid next cycle (flush, even if ifid_ready=1 that cycle) and go to REQ.
REQ-029 Redirect in IDLE SHALL be ignored.
REQ-030 pc+4 SHALL wrap modulo 2^PC_W with no flag.
REQ-031 Minimum loop latency SHALL be 3 cycles per instruction: REQ fire, WAIT with same-cycle response, OUT transfer.

Reset
REQ-032 While rst_n=0: state IDLE, pc=RESET_PC, discard=0, ifid_pc=0, ifid_instr=0, imem_req_valid=0, ifid_valid=0.
REQ-033 Assertion of rst_n mid-fetch SHALL abort immediately; a later stray imem_rsp_valid outside WAIT SHALL be ignored.

Verification
REQ-034 Reset release, ready=1, rsp next cycle with 0x2002_0001, ifid_ready=1 -> req addr 0x0, ifid_pc=0x0, ifid_instr=0x2002_0001, next req addr 0x4.
REQ-035 ifid_ready=0 for 5 cycles in OUT -> ifid_valid, ifid_pc and ifid_instr held; no new request until transfer.
REQ-036 branch_taken with target 0x40 in WAIT, rsp 0xDEAD_BEEF -> response dropped, next req addr 0x40, no ifid_valid for the 0xDEAD_BEEF response.
REQ-037 branch_taken with target 0x103 in OUT -> ifid_valid low next cycle, next req addr 0x100.
REQ-038 pc=0x1_FFFF_FFFC fetched -> next req addr 0x0.
REQ-039 imem_req_ready=0 for 3 cycles, then redirect to 0x80 -> addr stable at the old pc, then 0x80 from the following cycle, fire at 0x80.
